// File: rtl/window_streamer_if.sv
// Memory read bus and pixel output stream of the window streamer.
// The streamer drives the master side; the image buffer and the pixel consumer sit on the slave side.
interface window_streamer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [DATA_WIDTH-1:0] pix_data;
    logic [7:0]            pix_x;
    logic [7:0]            pix_y;

    modport master (
        output mem_rd_en, mem_addr, pix_valid, pix_data, pix_x, pix_y,
        input  mem_rd_data, pix_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, pix_valid, pix_data, pix_x, pix_y,
        output mem_rd_data, pix_ready
    );
endinterface

// File: rtl/window_streamer.sv
// Walks a padded-space window in raster order and streams its pixels.
// Real pixels are fetched from the image buffer; pixels in the padding ring are emitted as zero.
module window_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] image_dim,
    input  logic [1:0] padding,
    input  logic [7:0] x_min,
    input  logic [7:0] x_max,
    input  logic [7:0] y_min,
    input  logic [7:0] y_max,
    input  logic       start,
    output logic       busy,
    output logic       done,
    window_streamer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t state_q, state_d;

    // Latched job parameters
    logic [7:0] x_min_q, x_max_q, y_min_q, y_max_q, dim_q;
    logic [1:0] pad_q;

    // Walk position
    logic [7:0] cx, cy;

    // One-cycle slot stage: holds the slot issued last cycle while its read returns.
    logic       stg_valid;
    logic       stg_real;
    logic [7:0] stg_x, stg_y;

    // Two-entry output FIFO
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [7:0]            fifo_x    [2];
    logic [7:0]            fifo_y    [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_count;

    logic                  load, issue, issue_ok, last_slot;
    logic                  cur_real, push, pop;
    logic [8:0]            pad9, lim9;
    logic [ADDR_WIDTH-1:0] cur_addr;

    // Real-pixel test in 9 bits so padding+image_dim cannot overflow past 255.
    assign pad9     = {7'b0, pad_q};
    assign lim9     = pad9 + {1'b0, dim_q};
    assign cur_real = ({1'b0, cx} >= pad9) && ({1'b0, cx} < lim9) &&
                      ({1'b0, cy} >= pad9) && ({1'b0, cy} < lim9);
    assign cur_addr = ADDR_WIDTH'(cy - {6'b0, pad_q}) * ADDR_WIDTH'(dim_q) +
                      ADDR_WIDTH'(cx - {6'b0, pad_q});

    assign last_slot = (cx == x_max_q) && (cy == y_max_q);

    assign pop  = bus.pix_valid && bus.pix_ready;
    assign push = stg_valid;

    // A new slot may enter the stage only if the FIFO is guaranteed a free entry
    // when that slot lands; counting this cycle's pop keeps one pixel per cycle.
    assign issue_ok = ({1'b0, fifo_count} + {2'b0, stg_valid}) < (3'd2 + {2'b0, pop});

    assign bus.pix_valid = (fifo_count != 2'd0);
    assign bus.pix_data  = fifo_data[rd_ptr];
    assign bus.pix_x     = fifo_x[rd_ptr];
    assign bus.pix_y     = fifo_y[rd_ptr];

    assign bus.mem_rd_en = issue && cur_real;
    assign bus.mem_addr  = (issue && cur_real) ? cur_addr : '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, slot issue and status outputs
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if ((x_min > x_max) || (y_min > y_max)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (issue_ok) begin
                    issue = 1'b1;
                    if (last_slot) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!stg_valid && (fifo_count == 2'd0)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Job latch, raster walk, slot stage and output FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_min_q    <= '0;
            x_max_q    <= '0;
            y_min_q    <= '0;
            y_max_q    <= '0;
            dim_q      <= '0;
            pad_q      <= '0;
            cx         <= '0;
            cy         <= '0;
            stg_valid  <= 1'b0;
            stg_real   <= 1'b0;
            stg_x      <= '0;
            stg_y      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_x[i]    <= '0;
                fifo_y[i]    <= '0;
            end
        end else begin
            if (load) begin
                x_min_q <= x_min;
                x_max_q <= x_max;
                y_min_q <= y_min;
                y_max_q <= y_max;
                dim_q   <= image_dim;
                pad_q   <= padding;
                cx      <= x_min;
                cy      <= y_min;
            end

            // Wrap by comparing with the latched bound, never with cx+1,
            // so a window ending at 255 cannot alias through the overflow.
            if (issue) begin
                if (cx == x_max_q) begin
                    cx <= x_min_q;
                    cy <= cy + 8'd1;
                end else begin
                    cx <= cx + 8'd1;
                end
            end

            // Padding slots travel through the same stage as reads, so there is
            // only ever one FIFO push per cycle and raster order is kept for free.
            stg_valid <= issue;
            if (issue) begin
                stg_real <= cur_real;
                stg_x    <= cx;
                stg_y    <= cy;
            end

            if (push) begin
                fifo_data[wr_ptr] <= stg_real ? bus.mem_rd_data : '0;
                fifo_x[wr_ptr]    <= stg_x;
                fifo_y[wr_ptr]    <= stg_y;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_window_streamer.sv
// Self-checking bench for window_streamer: directed cases plus randomized windows,
// checked against a raster-order reference built from the window geometry.
module tb_window_streamer;

    logic       clk;
    logic       rst;
    logic [7:0] image_dim;
    logic [1:0] padding;
    logic [7:0] x_min, x_max, y_min, y_max;
    logic       start;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    window_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    window_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .image_dim (image_dim),
        .padding   (padding),
        .x_min     (x_min),
        .x_max     (x_max),
        .y_min     (y_min),
        .y_max     (y_max),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image buffer contents as a fixed function of the address
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        logic [7:0] v;
        v = a[7:0] * 8'd29;
        return v ^ a[15:8] ^ 8'h5A;
    endfunction

    // Image buffer: one-cycle read latency, junk on the bus when not reading
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem_val(bus.mem_addr);
        else               bus.mem_rd_data <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic junk_inputs();
        image_dim = 8'($urandom);
        padding   = 2'($urandom);
        x_min     = 8'($urandom);
        x_max     = 8'($urandom);
        y_min     = 8'($urandom);
        y_max     = 8'($urandom);
    endtask

    // mode: 0 ready high, 1 ready toggling 1010..., 2 random ready
    // rst_after: pulse reset after this many accepted pixels (-1: never)
    // poke: pulse start again while busy
    task automatic run_window(input int dim, input int pad, input int xmn, input int xmx,
                              input int ymn, input int ymx, input int mode,
                              input int rst_after, input bit poke);
        logic [7:0] exp_d[$];
        logic [7:0] exp_x[$];
        logic [7:0] exp_y[$];
        int         exp_a[$];
        int         n, acc, cyc, first_acc, last_acc, done_cyc, a;
        bit         fin, rp;
        logic       pv, pr;
        logic [7:0] pd, px, py;

        for (int y = ymn; y <= ymx; y++) begin
            for (int x = xmn; x <= xmx; x++) begin
                rp = (x >= pad) && (x < pad + dim) && (y >= pad) && (y < pad + dim);
                a  = (y - pad) * dim + (x - pad);
                exp_x.push_back(8'(x));
                exp_y.push_back(8'(y));
                if (rp) begin
                    exp_a.push_back(a);
                    exp_d.push_back(mem_val(16'(a)));
                end else begin
                    exp_d.push_back(8'd0);
                end
            end
        end
        n = exp_x.size();

        @(negedge clk);
        image_dim = 8'(dim);
        padding   = 2'(pad);
        x_min     = 8'(xmn);
        x_max     = 8'(xmx);
        y_min     = 8'(ymn);
        y_max     = 8'(ymx);
        start     = 1'b1;
        bus.pix_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        junk_inputs();

        pv = 1'b0; pr = 1'b0; pd = '0; px = '0; py = '0;
        acc = 0; fin = 1'b0; first_acc = -1; last_acc = -1; done_cyc = -1;
        for (cyc = 0; cyc < n * 6 + 20 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            case (mode)
                0:       bus.pix_ready = 1'b1;
                1:       bus.pix_ready = (cyc % 2 == 0);
                default: bus.pix_ready = 1'($urandom);
            endcase
            start = poke && (cyc == 3);
            #1;
            if (cyc == 0) chk("busy_after_start", busy, n > 0);
            if (pv && !pr) begin
                chk("hold_valid", bus.pix_valid, 1'b1);
                chk("hold_data", bus.pix_data, pd);
                chk("hold_x", bus.pix_x, px);
                chk("hold_y", bus.pix_y, py);
            end
            if (bus.mem_rd_en) begin
                if (exp_a.size() == 0) chk("unexpected_read", bus.mem_rd_en, 1'b0);
                else                   chk("mem_addr", bus.mem_addr, exp_a.pop_front());
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (exp_x.size() == 0) begin
                    chk("extra_pixel", bus.pix_valid, 1'b0);
                end else begin
                    chk("pix_data", bus.pix_data, exp_d.pop_front());
                    chk("pix_x", bus.pix_x, exp_x.pop_front());
                    chk("pix_y", bus.pix_y, exp_y.pop_front());
                end
                acc++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (acc == rst_after) begin
                    @(posedge clk);
                    #1 rst = 1'b1;
                    #1;
                    chk("rst_busy", busy, 1'b0);
                    chk("rst_done", done, 1'b0);
                    chk("rst_pix_valid", bus.pix_valid, 1'b0);
                    chk("rst_mem_rd_en", bus.mem_rd_en, 1'b0);
                    chk("rst_mem_addr", bus.mem_addr, 16'd0);
                    chk("rst_pix_data", bus.pix_data, 8'd0);
                    chk("rst_pix_x", bus.pix_x, 8'd0);
                    chk("rst_pix_y", bus.pix_y, 8'd0);
                    @(negedge clk);
                    rst   = 1'b0;
                    start = 1'b0;
                    return;
                end
            end
            if (done) begin
                fin      = 1'b1;
                done_cyc = cyc;
                chk("done_count", acc, n);
                chk("done_busy", busy, 1'b0);
                chk("done_reads_left", exp_a.size(), 0);
            end
            pv = bus.pix_valid;
            pr = bus.pix_ready;
            pd = bus.pix_data;
            px = bus.pix_x;
            py = bus.pix_y;
        end
        start = 1'b0;
        chk("done_seen", fin, 1'b1);
        if (fin && n == 0) chk("empty_done_latency", done_cyc <= 1, 1'b1);
        if (fin && mode == 0 && n > 0) chk("throughput", last_acc - first_acc, n - 1);
        @(negedge clk);
        #1;
        chk("done_pulse", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int dim, pad, p, xa, xb, ya, yb;
        rst = 1'b1;
        start = 1'b0;
        image_dim = '0; padding = '0;
        x_min = '0; x_max = '0; y_min = '0; y_max = '0;
        bus.pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_pix_valid", bus.pix_valid, 1'b0);
        chk("reset_mem_rd_en", bus.mem_rd_en, 1'b0);
        chk("reset_mem_addr", bus.mem_addr, 16'd0);
        chk("reset_pix_data", bus.pix_data, 8'd0);
        chk("reset_pix_x", bus.pix_x, 8'd0);
        chk("reset_pix_y", bus.pix_y, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        run_window(4, 0, 0, 2, 0, 2, 0, -1, 1'b0);   // plain 3x3 window
        run_window(4, 1, 0, 2, 0, 2, 0, -1, 1'b0);   // padding ring on row/col 0
        run_window(4, 0, 0, 2, 0, 2, 1, -1, 1'b0);   // ready toggling
        run_window(4, 0, 255, 0, 0, 2, 0, -1, 1'b0); // unprimed bounds
        run_window(4, 0, 0, 2, 5, 1, 0, -1, 1'b0);   // inverted y bounds
        run_window(4, 0, 0, 2, 0, 2, 0, 4, 1'b0);    // reset mid-stream
        run_window(4, 0, 0, 2, 0, 2, 0, -1, 1'b0);   // fresh start after reset
        run_window(4, 0, 0, 2, 0, 2, 0, -1, 1'b1);   // start while busy
        run_window(255, 0, 252, 255, 253, 255, 0, -1, 1'b0); // reaches 255, last column padding
        run_window(255, 3, 250, 255, 253, 255, 2, -1, 1'b0); // pad+dim beyond 255
        run_window(1, 3, 0, 6, 0, 6, 0, -1, 1'b0);   // single real pixel in a full ring

        for (int k = 0; k < 8; k++) begin
            dim = int'($urandom_range(1, 6));
            pad = int'($urandom_range(0, 3));
            p   = dim + 2 * pad;
            xa  = int'($urandom_range(0, p - 1));
            xb  = int'($urandom_range(xa, p - 1));
            ya  = int'($urandom_range(0, p - 1));
            yb  = int'($urandom_range(ya, p - 1));
            run_window(dim, pad, xa, xb, ya, yb, (k % 3 == 0) ? 0 : 2, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
